// File: rtl/mem_line_bridge_if.sv
// CPU-side word port and physical-memory-side line burst port of the bridge.
interface mem_line_bridge_if;
  // CPU word port
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  // physical memory burst port
  logic [31:0] pmem_address;
  logic        pmem_read;
  logic        pmem_write;
  logic [63:0] pmem_wdata;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;

  // driver side: the CPU plus the physical memory
  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata
  );

  // the bridge itself
  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp,
    output pmem_address, pmem_read, pmem_write, pmem_wdata
  );
endinterface

// File: rtl/mem_line_bridge.sv
// Word-to-line bridge: every CPU access fetches the 256-bit line in four
// 64-bit beats; writes merge their bytes and write the whole line back.
module mem_line_bridge (
  input  logic          clk,
  input  logic          rst,
  mem_line_bridge_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t       state, state_d;
  logic [1:0]   cnt, cnt_d;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [3:0]   be;
  logic         is_write;
  logic [255:0] line, line_d;
  logic         resp_q;
  logic         accept;
  logic [2:0]   word;
  logic [31:0]  merged;

  assign word = addr[4:2];

  // resp_q blocks acceptance in the IDLE cycle right after RESP, so a CPU
  // that keeps its request asserted gets a clean gap between transactions
  assign accept = (state == IDLE) && (bus.mem_read || bus.mem_write) && !resp_q;

  // next-state, beat counter and line buffer update (incl. write merge)
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    line_d  = line;
    merged  = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_d = READ;
          cnt_d   = 2'd0;
        end
      end
      READ: begin
        if (bus.pmem_resp) begin
          line_d[{cnt, 6'b0} +: 64] = bus.pmem_rdata;
          cnt_d = cnt + 2'd1;
          if (cnt == 2'd3) begin
            if (is_write) begin
              // merge on the freshly completed line, including beat 3
              merged = line_d[{word, 5'b0} +: 32];
              for (int i = 0; i < 4; i++)
                if (be[i]) merged[i*8 +: 8] = wdata[i*8 +: 8];
              line_d[{word, 5'b0} +: 32] = merged;
              cnt_d   = 2'd0;
              state_d = WRITE;
            end else begin
              state_d = RESP;
            end
          end
        end
      end
      WRITE: begin
        if (bus.pmem_resp) begin
          cnt_d = cnt + 2'd1;
          if (cnt == 2'd3) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state, counters, request latches and line buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      addr     <= '0;
      wdata    <= '0;
      be       <= '0;
      is_write <= 1'b0;
      line     <= '0;
      resp_q   <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      line   <= line_d;
      resp_q <= (state == RESP);
      if (accept) begin
        addr     <= bus.mem_address;
        wdata    <= bus.mem_wdata;
        be       <= bus.mem_byte_enable;
        // read+write together is treated as a write
        is_write <= bus.mem_write;
      end
    end
  end

  assign bus.pmem_address = {addr[31:5], 5'b0};
  assign bus.pmem_read    = (state == READ);
  assign bus.pmem_write   = (state == WRITE);
  assign bus.pmem_wdata   = (state == WRITE) ? line[{cnt, 6'b0} +: 64] : 64'd0;
  assign bus.mem_resp     = (state == RESP);
  assign bus.mem_rdata    = (state == RESP) ? line[{word, 5'b0} +: 32] : 32'd0;
endmodule

// File: tb/tb_mem_line_bridge.sv
// Directed bench for mem_line_bridge with a beat-level physical memory model.
module tb_mem_line_bridge;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_line_bridge_if bus ();

  mem_line_bridge dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vec = 0;
  int errs = 0;

  // physical memory model: lines selected by address bits [14:12]
  logic [255:0] pmem_mem [0:7];
  logic [1:0]   mbeat = 2'd0;
  int           wcnt = 0;
  int           wait_n = 0;
  logic         stray = 1'b0;
  logic         load_en = 1'b0;
  logic [2:0]   load_idx = 3'd0;
  logic [255:0] load_val = '0;
  int           beats_served = 0;
  int           resp_cnt = 0;
  int           both_cnt = 0;
  int           wr_seen = 0;
  logic [2:0]   key;
  logic         active;

  assign key            = bus.pmem_address[14:12];
  assign active         = bus.pmem_read | bus.pmem_write;
  assign bus.pmem_resp  = (active && (wcnt == wait_n)) || stray;
  assign bus.pmem_rdata = pmem_mem[key][{mbeat, 6'b0} +: 64];

  // memory model and event counters
  always @(posedge clk) begin
    if (bus.mem_resp) resp_cnt <= resp_cnt + 1;
    if (bus.pmem_read && bus.pmem_write) both_cnt <= both_cnt + 1;
    if (bus.pmem_write) wr_seen <= wr_seen + 1;
    if (load_en) pmem_mem[load_idx] <= load_val;
    if (!active) begin
      wcnt  <= 0;
      mbeat <= 2'd0;
    end else if (bus.pmem_resp) begin
      wcnt         <= 0;
      mbeat        <= mbeat + 2'd1;
      beats_served <= beats_served + 1;
      if (bus.pmem_write) pmem_mem[key][{mbeat, 6'b0} +: 64] <= bus.pmem_wdata;
    end else begin
      wcnt <= wcnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [2:0] idx, input logic [255:0] val);
    load_idx = idx;
    load_val = val;
    load_en  = 1'b1;
    tick();
    load_en  = 1'b0;
  endtask

  // ticks until mem_resp is seen; n = cycles after the request was sampled, -1 on timeout
  task automatic wait_resp(output int n);
    n = -1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (bus.mem_resp) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic idle_cpu();
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = 4'b0;
    bus.mem_wdata       = 32'd0;
  endtask

  localparam logic [255:0] LINE1 = {64'h7777_0000_8888_0004, 64'h5555_0000_6666_0003,
                                    64'h3333_0000_4444_0002, 64'h1111_0000_2222_0001};

  task automatic test_reset();
    idle_cpu();
    bus.mem_address = 32'hFFFF_FFFF;
    rst = 1'b1;
    tick(); tick();
    vec++; if (bus.mem_resp !== 1'b0) begin errs++; $display("FAIL reset_mem_resp: got %b want 0", bus.mem_resp); end
    vec++; if ({bus.pmem_read, bus.pmem_write} !== 2'b00) begin errs++; $display("FAIL reset_pmem_rw: got %b want 00", {bus.pmem_read, bus.pmem_write}); end
    vec++; if (bus.pmem_address !== 32'd0) begin errs++; $display("FAIL reset_pmem_address: got %h want 0", bus.pmem_address); end
    vec++; if (bus.pmem_wdata !== 64'd0) begin errs++; $display("FAIL reset_pmem_wdata: got %h want 0", bus.pmem_wdata); end
    vec++; if (bus.mem_rdata !== 32'd0) begin errs++; $display("FAIL reset_mem_rdata: got %h want 0", bus.mem_rdata); end
    rst = 1'b0;
    // stray acknowledges while idle must do nothing
    stray = 1'b1;
    tick(); tick();
    stray = 1'b0;
    tick();
    vec++; if (bus.pmem_read !== 1'b0 || resp_cnt !== 0) begin errs++; $display("FAIL idle_stray_resp: got pmem_read=%b resp_cnt=%0d want 0/0", bus.pmem_read, resp_cnt); end
  endtask

  task automatic test_read();
    int n, r0;
    preload(3'd1, LINE1);
    r0 = resp_cnt;
    bus.mem_address = 32'h0000_1004;
    bus.mem_read    = 1'b1;
    wait_resp(n);
    vec++; if (n !== 5) begin errs++; $display("FAIL read_latency: got %0d want 5", n); end
    vec++; if (bus.mem_rdata !== 32'h1111_0000) begin errs++; $display("FAIL read_data: got %h want 11110000", bus.mem_rdata); end
    vec++; if (bus.pmem_address !== 32'h0000_1000) begin errs++; $display("FAIL read_pmem_address: got %h want 00001000", bus.pmem_address); end
    idle_cpu();
    tick(); tick();
    vec++; if (resp_cnt - r0 !== 1) begin errs++; $display("FAIL read_resp_count: got %0d want 1", resp_cnt - r0); end
  endtask

  task automatic test_write();
    int n, w0;
    preload(3'd2, {8{32'hAAAA_AAAA}});
    w0 = wr_seen;
    bus.mem_address     = 32'h0000_201C;
    bus.mem_write       = 1'b1;
    bus.mem_byte_enable = 4'b0011;
    bus.mem_wdata       = 32'h1234_5678;
    wait_resp(n);
    vec++; if (n !== 9) begin errs++; $display("FAIL write_latency: got %0d want 9", n); end
    vec++; if (bus.mem_rdata !== 32'hAAAA_5678) begin errs++; $display("FAIL write_rdata: got %h want aaaa5678", bus.mem_rdata); end
    idle_cpu();
    tick(); tick();
    vec++; if (pmem_mem[2] !== {32'hAAAA_5678, {7{32'hAAAA_AAAA}}}) begin errs++; $display("FAIL write_line: got %h", pmem_mem[2]); end
    vec++; if (wr_seen - w0 !== 4) begin errs++; $display("FAIL write_beats: got %0d want 4", wr_seen - w0); end
  endtask

  task automatic test_zero_be();
    int n;
    logic [255:0] l5;
    l5 = 256'h8888_7777_6666_5555_4444_3333_2222_1111_0fed_cba9_8765_4321_dead_beef_cafe_f00d;
    preload(3'd5, l5);
    bus.mem_address     = 32'h0000_5010;
    bus.mem_write       = 1'b1;
    bus.mem_byte_enable = 4'b0000;
    bus.mem_wdata       = 32'hFFFF_FFFF;
    wait_resp(n);
    vec++; if (n !== 9) begin errs++; $display("FAIL zero_be_latency: got %0d want 9", n); end
    vec++; if (bus.mem_rdata !== 32'h2222_1111) begin errs++; $display("FAIL zero_be_rdata: got %h want 22221111", bus.mem_rdata); end
    idle_cpu();
    tick(); tick();
    vec++; if (pmem_mem[5] !== l5) begin errs++; $display("FAIL zero_be_line: got %h", pmem_mem[5]); end
  endtask

  task automatic test_wait_states();
    int n, b0, r0, drops;
    wait_n = 2;
    b0 = beats_served;
    r0 = resp_cnt;
    drops = 0;
    n = -1;
    bus.mem_address = 32'h0000_1018;
    bus.mem_read    = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (bus.mem_resp) begin
        n = k;
        break;
      end
      if (!bus.pmem_read) drops++;
    end
    vec++; if (n !== 13) begin errs++; $display("FAIL wait_latency: got %0d want 13", n); end
    vec++; if (drops !== 0) begin errs++; $display("FAIL wait_pmem_read_held: got %0d drop cycles want 0", drops); end
    vec++; if (bus.mem_rdata !== 32'h8888_0004) begin errs++; $display("FAIL wait_data: got %h want 88880004", bus.mem_rdata); end
    idle_cpu();
    tick(); tick();
    vec++; if (beats_served - b0 !== 4) begin errs++; $display("FAIL wait_beats: got %0d want 4", beats_served - b0); end
    vec++; if (resp_cnt - r0 !== 1) begin errs++; $display("FAIL wait_resp_count: got %0d want 1", resp_cnt - r0); end
    wait_n = 0;
  endtask

  task automatic test_rw_both();
    int n, w0;
    preload(3'd3, {8{32'h0101_0101}});
    w0 = wr_seen;
    bus.mem_address     = 32'h0000_3008;
    bus.mem_read        = 1'b1;
    bus.mem_write       = 1'b1;
    bus.mem_byte_enable = 4'b1111;
    bus.mem_wdata       = 32'hDEAD_BEEF;
    wait_resp(n);
    vec++; if (n !== 9) begin errs++; $display("FAIL rw_latency: got %0d want 9", n); end
    vec++; if (bus.mem_rdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL rw_rdata: got %h want deadbeef", bus.mem_rdata); end
    idle_cpu();
    tick(); tick();
    vec++; if (wr_seen - w0 !== 4) begin errs++; $display("FAIL rw_write_seen: got %0d want 4", wr_seen - w0); end
    vec++; if (pmem_mem[3] !== {{5{32'h0101_0101}}, 32'hDEAD_BEEF, {2{32'h0101_0101}}}) begin errs++; $display("FAIL rw_line: got %h", pmem_mem[3]); end
  endtask

  task automatic test_reset_mid();
    int n, r0;
    r0 = resp_cnt;
    bus.mem_address = 32'h0000_1004;
    bus.mem_read    = 1'b1;
    tick(); tick(); tick();   // two beats done, third on the bus
    idle_cpu();
    rst = 1'b1;
    tick();
    vec++; if (bus.pmem_read !== 1'b0 || bus.mem_resp !== 1'b0) begin errs++; $display("FAIL rst_mid_outputs: got pmem_read=%b mem_resp=%b want 0/0", bus.pmem_read, bus.mem_resp); end
    vec++; if (bus.pmem_address !== 32'd0) begin errs++; $display("FAIL rst_mid_address: got %h want 0", bus.pmem_address); end
    stray = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();
    stray = 1'b0;
    tick();
    vec++; if (bus.pmem_read !== 1'b0 || resp_cnt !== r0) begin errs++; $display("FAIL rst_mid_stray: got pmem_read=%b resps=%0d want 0/0", bus.pmem_read, resp_cnt - r0); end
    bus.mem_address = 32'h0000_1004;
    bus.mem_read    = 1'b1;
    wait_resp(n);
    vec++; if (n !== 5 || bus.mem_rdata !== 32'h1111_0000) begin errs++; $display("FAIL rst_mid_recover: got lat=%0d data=%h want 5/11110000", n, bus.mem_rdata); end
    idle_cpu();
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    int n, r0;
    preload(3'd4, {{7{32'h0404_0404}}, 32'h4444_0000});
    r0 = resp_cnt;
    bus.mem_address = 32'h0000_1008;
    bus.mem_read    = 1'b1;
    wait_resp(n);
    vec++; if (n !== 5 || bus.mem_rdata !== 32'h4444_0002) begin errs++; $display("FAIL b2b_first: got lat=%0d data=%h want 5/44440002", n, bus.mem_rdata); end
    bus.mem_address = 32'h0000_4000;   // request stays asserted
    tick(); tick();
    vec++; if (bus.pmem_read !== 1'b0) begin errs++; $display("FAIL b2b_idle_gap: got pmem_read=%b want 0", bus.pmem_read); end
    wait_resp(n);
    vec++; if (n !== 5 || bus.mem_rdata !== 32'h4444_0000) begin errs++; $display("FAIL b2b_second: got lat=%0d data=%h want 5/44440000", n, bus.mem_rdata); end
    idle_cpu();
    tick(); tick();
    vec++; if (resp_cnt - r0 !== 2) begin errs++; $display("FAIL b2b_resp_count: got %0d want 2", resp_cnt - r0); end
    vec++; if (both_cnt !== 0) begin errs++; $display("FAIL rw_exclusive: got %0d overlap cycles want 0", both_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    idle_cpu();
    bus.mem_address = 32'd0;
    test_reset();
    test_read();
    test_write();
    test_zero_be();
    test_wait_states();
    test_rw_both();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
